// File: rtl/issue_stage.sv
// Issue stage: register scoreboard, hazard stall and execute-stage pipeline registers.
// Ports: clock/reset, decode bundle in, regfile read port, writeback retire in, stall + execute regs out.
module issue_stage #(
  parameter int INFLIGHT_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_is_valid,
  input  logic [4:0]  id_is_addra,
  input  logic [4:0]  id_is_addrb,
  input  logic        id_is_usea,
  input  logic        id_is_useb,
  input  logic [4:0]  id_is_regdest,
  input  logic        id_is_writereg,
  input  logic [15:0] id_is_ctrl,
  input  logic [31:0] id_is_imedext,
  output logic [4:0]  is_reg_addra,
  output logic [4:0]  is_reg_addrb,
  input  logic [31:0] reg_is_dataa,
  input  logic [31:0] reg_is_datab,
  input  logic        wb_is_writereg,
  input  logic [4:0]  wb_is_regdest,
  output logic        is_stall,
  output logic        is_ex_valid,
  output logic [31:0] is_ex_rega,
  output logic [31:0] is_ex_regb,
  output logic [31:0] is_ex_imedext,
  output logic [15:0] is_ex_ctrl,
  output logic [4:0]  is_ex_regdest,
  output logic        is_ex_writereg
);

  localparam logic [2:0] MAX3 = 3'(INFLIGHT_MAX);

  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic [2:0]  inflight;
  logic [2:0]  inflight_nxt;

  logic src_haz;
  logic cap_haz;
  logic issue;
  logic inc;
  logic dec;

  assign is_reg_addra = id_is_addra;
  assign is_reg_addrb = id_is_addrb;

  // pending[0] is held at zero, so r0 sources never hazard
  assign src_haz = id_is_valid &&
                   ((id_is_usea && pending[id_is_addra]) ||
                    (id_is_useb && pending[id_is_addrb]));

  assign cap_haz = id_is_valid && id_is_writereg &&
                   (id_is_regdest != 5'd0) &&
                   (inflight == MAX3);

  assign is_stall = src_haz || cap_haz;
  assign issue    = id_is_valid && !is_stall;

  assign inc = issue && id_is_writereg &&
               (id_is_regdest != 5'd0);

  // retiring a register that is not pending is ignored
  assign dec = wb_is_writereg &&
               (wb_is_regdest != 5'd0) &&
               pending[wb_is_regdest];

  always_comb begin
    set_vec = 32'd0;
    clr_vec = 32'd0;
    if (inc) set_vec[id_is_regdest] = 1'b1;
    if (dec) clr_vec[wb_is_regdest] = 1'b1;
  end

  // set applied after clear: same-register set+clear stays pending
  assign pending_nxt = ((pending & ~clr_vec) | set_vec) &
                       32'hFFFF_FFFE;

  always_comb begin
    inflight_nxt = inflight;
    unique case (1'b1)
      (inc && !dec): begin
        if (inflight != MAX3)
          inflight_nxt = inflight + 3'd1;
      end
      (dec && !inc): begin
        if (inflight != 3'd0)
          inflight_nxt = inflight - 3'd1;
      end
      default: inflight_nxt = inflight;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending  <= 32'd0;
      inflight <= 3'd0;
    end else begin
      pending  <= pending_nxt;
      inflight <= inflight_nxt;
    end
  end

  // data fields load every cycle; a bubble only kills valid/writereg/ctrl
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      is_ex_valid    <= 1'b0;
      is_ex_rega     <= 32'd0;
      is_ex_regb     <= 32'd0;
      is_ex_imedext  <= 32'd0;
      is_ex_ctrl     <= 16'd0;
      is_ex_regdest  <= 5'd0;
      is_ex_writereg <= 1'b0;
    end else begin
      is_ex_rega    <= reg_is_dataa;
      is_ex_regb    <= reg_is_datab;
      is_ex_imedext <= id_is_imedext;
      is_ex_regdest <= id_is_regdest;
      if (issue) begin
        is_ex_valid    <= 1'b1;
        is_ex_ctrl     <= id_is_ctrl;
        is_ex_writereg <= id_is_writereg;
      end else begin
        is_ex_valid    <= 1'b0;
        is_ex_ctrl     <= 16'd0;
        is_ex_writereg <= 1'b0;
      end
    end
  end

endmodule

// File: doc/issue_stage.md
ISSUE_STAGE -- requirements
Module: issue_stage

Interface
REQ-001 Parameter INFLIGHT_MAX, default 4: maximum register-writing instructions issued but not yet written back (1..7).
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low; all state cleared while low.
REQ-004 id_is_valid  in  1  decode presents an instruction this cycle.
REQ-005 id_is_addra, id_is_addrb  in  5 each  source register numbers (rs, rt).
REQ-006 id_is_usea, id_is_useb  in  1 each  instruction reads rs / rt.
REQ-007 id_is_regdest  in  5  destination register; id_is_writereg  in  1  instruction writes it.
REQ-008 id_is_ctrl  in  16  opaque decoded control bundle (aluop, shiftop, selects, readmem, writemem, ...); bit 0 = writemem.
REQ-009 id_is_imedext  in  32  sign-extended immediate.
REQ-010 is_reg_addra, is_reg_addrb  out  5 each  register-file read addresses.
REQ-011 reg_is_dataa, reg_is_datab  in  32 each  register-file read data, combinational from addresses.
REQ-012 wb_is_writereg  in  1, wb_is_regdest  in  5  writeback retire notification.
REQ-013 is_stall  out  1  hold decode (decode keeps instruction and its outputs).
REQ-014 is_ex_valid  out  1; is_ex_rega, is_ex_regb, is_ex_imedext  out  32 each; is_ex_ctrl  out  16; is_ex_regdest  out  5; is_ex_writereg  out  1  registered execute-stage inputs.

Function
REQ-015 is_reg_addra/addrb SHALL equal id_is_addra/addrb combinationally.
REQ-016 Scoreboard SHALL hold one pending bit per register 1..31; register 0 SHALL never be pending and never cause a stall.
REQ-017 A source hazard SHALL exist when id_is_valid and ((usea and pending[addra]) or (useb and pending[addrb])), using the scoreboard value registered at the start of the cycle (no same-cycle writeback bypass).
REQ-018 A capacity hazard SHALL exist when id_is_valid, id_is_writereg, regdest != 0 and inflight count == INFLIGHT_MAX.
REQ-019 is_stall SHALL be combinational: 1 exactly when either hazard exists.
REQ-020 Issue occurs when id_is_valid and not is_stall; on the next edge execute registers SHALL load valid=1, dataa, datab, imedext, ctrl, regdest, writereg.
REQ-021 When no issue occurs, execute registers SHALL load a bubble: valid=0, writereg=0, ctrl=0 (writemem=0); data fields SHALL be don't-care.
REQ-022 Issue with writereg=1 and regdest != 0 SHALL set pending[regdest] and increment inflight.
REQ-023 wb_is_writereg=1 with wb_is_regdest != 0 SHALL clear pending[wb_is_regdest] and decrement inflight; retirement of a non-pending register SHALL change nothing.
REQ-024 Simultaneous set and clear of the same register SHALL leave it pending; inflight unchanged when both increment and decrement occur.
REQ-025 Inflight SHALL saturate neither direction beyond 0..INFLIGHT_MAX; latency decode-to-execute is exactly one cycle when not stalled.

Reset
REQ-026 While reset low: all pending bits 0, inflight 0, is_ex_valid 0, is_ex_writereg 0, is_ex_ctrl 0, is_ex_regdest 0, data outputs 0.
REQ-027 Reset asserted mid-stall SHALL drop is_stall to 0 immediately (scoreboard empty) and discard in-flight tracking.

Verification
REQ-028 Issue ADD r3<-r1,r2 with reg r1=5, r2=7 -> next cycle is_ex_valid=1, rega=5, regb=7, regdest=3, pending[3]=1, inflight=1.
REQ-029 Back-to-back dependent: r3 producer then reader of r3 -> is_stall=1, bubble (valid=0, writemem=0) each cycle until wb_is_regdest=3 pulse; reader issues the cycle after retirement.
REQ-030 Producer to r0 then reader of r0 -> no stall, inflight stays 0.
REQ-031 INFLIGHT_MAX=4: four independent writers issue, fifth writer stalls; one retire -> fifth issues next cycle; non-writing instruction during full state issues without stall.
REQ-032 Same cycle: issue writer to r5 and retire r5 -> pending[5]=1, inflight unchanged.
REQ-033 Assert reset while stalled on r3 -> is_stall=0, is_ex_valid=0, all pending 0; after release, r3 reader issues without stall.
